// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller that launches,
// supervises and times a processor core run.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int          RUN_CNT_W      = 16;
    localparam int unsigned RUN_MAX_CYCLES = 50000;
    localparam int          RUN_START_HOLD = 2;

    function automatic logic is_busy(input state_t s);
        return (s == INIT) || (s == RUN);
    endfunction

endpackage

// File: rtl/run_ctrl.sv
// Responder side of the req/done handshake: holds the core in reset, lets it
// run, and finishes on halt or watchdog expiry while counting RUN cycles.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          CNT_W      = RUN_CNT_W,
    parameter int unsigned MAX_CYCLES = RUN_MAX_CYCLES,
    parameter int          START_HOLD = RUN_START_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             core_halt,
    output logic             core_rst,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [3:0]       HOLD_LAST = 4'(START_HOLD - 1);
    localparam bit               WD_EN     = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST   = WD_EN ? CNT_W'(MAX_CYCLES - 1) : '0;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_reqQ;
    logic [3:0]       r_holdCnt;
    logic [CNT_W-1:0] r_cycleCount;
    logic             r_done;
    logic             r_timeout;

    logic             w_launch;
    logic             w_startRun;
    logic             w_holdDone;
    logic             w_cntMax;
    logic             w_watchdog;

    assign w_launch   = req & ~r_reqQ;
    assign w_startRun = w_launch && ((r_state == IDLE) || (r_state == FIN));
    assign w_holdDone = (r_holdCnt == HOLD_LAST);
    assign w_cntMax   = &r_cycleCount;
    assign w_watchdog = WD_EN && (r_cycleCount == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Launches are only honoured when idle or finished; INIT/RUN drop them.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: if (w_launch) w_nextState = INIT;
            INIT: if (w_holdDone) w_nextState = RUN;
            RUN:  if (core_halt || w_watchdog) w_nextState = FIN;
            FIN:  if (w_launch) w_nextState = INIT;
            default: w_nextState = IDLE;
        endcase
    end

    // Moore decode: core controls depend on the state register alone.
    always_comb begin
        core_rst = 1'b1;
        core_en  = 1'b0;
        unique case (r_state)
            IDLE, INIT: begin
                core_rst = 1'b1;
                core_en  = 1'b0;
            end
            RUN: begin
                core_rst = 1'b0;
                core_en  = 1'b1;
            end
            FIN: begin
                core_rst = 1'b0;
                core_en  = 1'b0;
            end
            default: begin
                core_rst = 1'b1;
                core_en  = 1'b0;
            end
        endcase
        busy = is_busy(r_state);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reqQ <= 1'b0;
        end else begin
            r_reqQ <= req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_holdCnt <= '0;
        end else if (w_startRun) begin
            r_holdCnt <= '0;
        end else if (r_state == INIT) begin
            r_holdCnt <= r_holdCnt + 4'd1;
        end
    end

    // Saturating so a long run without a watchdog never reports a small count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycleCount <= '0;
        end else if (w_startRun) begin
            r_cycleCount <= '0;
        end else if ((r_state == RUN) && !w_cntMax) begin
            r_cycleCount <= r_cycleCount + 1'b1;
        end
    end

    // Halt takes priority over the watchdog when both land on one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_startRun) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (r_state == RUN) begin
            if (core_halt) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_watchdog) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycleCount;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed and randomized runs against a run-level model
// of expected finish cycle, timeout flag and cycle count.
module tb_run_ctrl;

    localparam int HOLD  = 2;
    localparam int MAXC  = 20;
    localparam int SAT_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             req;
    logic             coreHalt;
    logic             coreRst;
    logic             coreEn;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [15:0]      cycleCount;

    logic             req2;
    logic             coreHalt2;
    logic             coreRst2;
    logic             coreEn2;
    logic             busy2;
    logic             done2;
    logic             timeout2;
    logic [SAT_W-1:0] cycleCount2;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    run_ctrl #(.CNT_W(16), .MAX_CYCLES(MAXC), .START_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .core_halt(coreHalt),
        .core_rst(coreRst), .core_en(coreEn), .busy(busy), .done(done),
        .timeout(timeout), .cycle_count(cycleCount)
    );

    // Watchdog disabled and a narrow counter so saturation is reached quickly.
    run_ctrl #(.CNT_W(SAT_W), .MAX_CYCLES(0), .START_HOLD(1)) dutSat (
        .clk(clk), .reset(reset), .req(req2), .core_halt(coreHalt2),
        .core_rst(coreRst2), .core_en(coreEn2), .busy(busy2), .done(done2),
        .timeout(timeout2), .cycle_count(cycleCount2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One complete run; expectations come from the run-level rules only.
    task automatic applyStimulus(input int haltAt, input int reqAt, input bit holdReq, input string tag);
        bit haltWins;
        int endCycle;
        logic [15:0] finalCount;
        haltWins = (haltAt >= 1) && (haltAt <= MAXC);
        endCycle = haltWins ? haltAt : MAXC;

        req = 1'b1;
        tick();
        checkOutput({tag, "_launchDoneClr"}, 32'(done), 32'd0);
        checkOutput({tag, "_launchCnt"}, 32'(cycleCount), 32'd0);
        req = holdReq;
        for (int j = 0; j < HOLD; j++) begin
            checkOutput({tag, "_initRst"}, 32'(coreRst), 32'd1);
            checkOutput({tag, "_initEn"}, 32'(coreEn), 32'd0);
            checkOutput({tag, "_initBusy"}, 32'(busy), 32'd1);
            coreHalt = 1'($urandom_range(0, 1));
            tick();
        end
        coreHalt = 1'b0;
        for (int k = 1; k <= endCycle; k++) begin
            checkOutput({tag, "_runEn"}, 32'(coreEn), 32'd1);
            checkOutput({tag, "_runRst"}, 32'(coreRst), 32'd0);
            checkOutput({tag, "_runCnt"}, 32'(cycleCount), 32'(k - 1));
            checkOutput({tag, "_runDone"}, 32'(done), 32'd0);
            coreHalt = (k == haltAt);
            req = holdReq | (k == reqAt);
            tick();
        end
        coreHalt = 1'b0;
        req = holdReq;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_timeout"}, 32'(timeout), haltWins ? 32'd0 : 32'd1);
        checkOutput({tag, "_count"}, 32'(cycleCount), 32'(endCycle));
        checkOutput({tag, "_finEn"}, 32'(coreEn), 32'd0);
        checkOutput({tag, "_finRst"}, 32'(coreRst), 32'd0);
        checkOutput({tag, "_finBusy"}, 32'(busy), 32'd0);
        finalCount = cycleCount;
        for (int j = 0; j < 3; j++) begin
            coreHalt = 1'($urandom_range(0, 1));
            tick();
            checkOutput({tag, "_holdDone"}, 32'(done), 32'd1);
            checkOutput({tag, "_holdTimeout"}, 32'(timeout), haltWins ? 32'd0 : 32'd1);
            checkOutput({tag, "_holdCnt"}, 32'(cycleCount), 32'(endCycle));
            checkOutput({tag, "_holdBusy"}, 32'(busy), 32'd0);
        end
        coreHalt = 1'b0;
        checkOutput({tag, "_frozen"}, 32'(cycleCount), 32'(finalCount));
    endtask

    initial begin
        int haltAt;
        int reqAt;
        reset = 1'b0;
        req = 1'b0;
        coreHalt = 1'b0;
        req2 = 1'b0;
        coreHalt2 = 1'b0;
        repeat (2) tick();
        checkOutput("rstCoreRst", 32'(coreRst), 32'd1);
        checkOutput("rstCoreEn", 32'(coreEn), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstTimeout", 32'(timeout), 32'd0);
        checkOutput("rstCount", 32'(cycleCount), 32'd0);
        reset = 1'b1;
        tick();

        applyStimulus(7, 0, 1'b0, "halt7");
        applyStimulus(0, 0, 1'b0, "watchdog");
        applyStimulus(20, 0, 1'b0, "haltAtLimit");
        applyStimulus(21, 0, 1'b0, "haltLate");
        applyStimulus(9, 3, 1'b0, "reqInRun");
        applyStimulus(4, 0, 1'b0, "relaunchFin");

        for (int r = 0; r < 6; r++) begin
            haltAt = int'($urandom_range(0, 24));
            reqAt = int'($urandom_range(0, 12));
            applyStimulus(haltAt, reqAt, 1'b0, "random");
        end

        // req held through reset release launches once and never relaunches.
        reset = 1'b0;
        req = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        applyStimulus(5, 0, 1'b1, "heldReq");
        repeat (4) tick();
        checkOutput("heldNoRelaunchBusy", 32'(busy), 32'd0);
        checkOutput("heldNoRelaunchDone", 32'(done), 32'd1);
        req = 1'b0;
        tick();

        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (HOLD) tick();
        repeat (5) tick();
        checkOutput("midRunCnt", 32'(cycleCount), 32'd5);
        checkOutput("midRunEn", 32'(coreEn), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("asyncRstCoreRst", 32'(coreRst), 32'd1);
        checkOutput("asyncRstCoreEn", 32'(coreEn), 32'd0);
        checkOutput("asyncRstDone", 32'(done), 32'd0);
        checkOutput("asyncRstCount", 32'(cycleCount), 32'd0);
        checkOutput("asyncRstBusy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("afterRstDone", 32'(done), 32'd0);
        checkOutput("afterRstBusy", 32'(busy), 32'd0);

        req2 = 1'b1;
        tick();
        req2 = 1'b0;
        tick();
        checkOutput("satRunEn", 32'(coreEn2), 32'd1);
        checkOutput("satStartCnt", 32'(cycleCount2), 32'd0);
        repeat ((1 << SAT_W) - 2) tick();
        checkOutput("satBelowMax", 32'(cycleCount2), 32'((1 << SAT_W) - 2));
        tick();
        checkOutput("satAtMax", 32'(cycleCount2), 32'((1 << SAT_W) - 1));
        repeat (40) tick();
        checkOutput("satHeld", 32'(cycleCount2), 32'((1 << SAT_W) - 1));
        checkOutput("satNoDone", 32'(done2), 32'd0);
        checkOutput("satNoTimeout", 32'(timeout2), 32'd0);
        checkOutput("satBusy", 32'(busy2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Responder side of the top-level req/done handshake: accepts a launch request from the bench or host, holds the core in reset, releases it to run, and watches for the core's halt.
- Raises done when the program halts or a cycle watchdog expires.
- Sits inside top_level between the external req/done pins and the processor core (PC/fetch reset and enable).
- Also reports the executed cycle count for performance measurement.

Parameters:
- CNT_W, 16: width of cycle counter and watchdog compare.
- MAX_CYCLES, 16'd50000: watchdog limit in RUN cycles; 0 disables the watchdog.
- START_HOLD, 2: cycles core_rst stays asserted in INIT before RUN (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0), applies to all state.
- req  input  1  launch request; level input, rising edge launches a run.
- core_halt  input  1  core's halt indication, sampled only in RUN.
- core_rst  output  1  synchronous reset to core (PC=0, pipeline cleared).
- core_en  output  1  core clock-enable / advance.
- busy  output  1  high in INIT or RUN.
- done  output  1  run finished (halt or timeout), held until next launch.
- timeout  output  1  last run ended by watchdog, valid while done=1.
- cycle_count  output  CNT_W  RUN cycles of last or current run.

Behaviour:
- Reset values, asynchronous on reset=0: state=IDLE, req_q=0, hold_cnt=0, cycle_count=0, done=0, timeout=0, core_rst=1, core_en=0, busy=0.
- Launch event is req & ~req_q, where req_q is req registered each clk. Because req_q resets to 0, a req held high through reset release launches on the first edge.
- IDLE: core_rst=1, core_en=0. On launch: go to INIT, clear done, timeout, cycle_count and hold_cnt.
- INIT: core_rst=1, core_en=0, hold_cnt increments. When hold_cnt==START_HOLD-1, go to RUN on that edge.
  - Latency: launch sampled at edge N puts state in RUN after edge N+START_HOLD.
- RUN: core_rst=0, core_en=1, cycle_count increments every RUN cycle, including the halt cycle. Counter saturates at all-ones and never wraps.
  - core_halt=1 at edge M: go to FIN; done=1, timeout=0 after edge M.
  - Watchdog: MAX_CYCLES!=0, cycle_count==MAX_CYCLES-1 and core_halt=0 → FIN, done=1, timeout=1. cycle_count ends equal to MAX_CYCLES.
  - Halt and watchdog on the same edge: halt wins, timeout=0.
- FIN: core_rst=0, core_en=0 so core and memory state stay inspectable. done held at 1, cycle_count frozen.
  - Launch in FIN: go to INIT with the same clears as in IDLE; done falls after that edge.
- Launch edges seen in INIT or RUN are ignored and not queued. req falling never affects state.
- core_halt outside RUN is ignored.
- reset asserted mid-INIT or mid-RUN: immediate return to reset values; done never pulses.
- All outputs are registered except busy and core_en/core_rst, which may be decoded from the state register. These must be glitch-free: a Moore decode only.

Decomposition:
- Package run_ctrl_pkg holds:
  - state_t enum: IDLE, INIT, RUN, FIN (2-bit encoding).
  - Default constants RUN_CNT_W=16, RUN_MAX_CYCLES, RUN_START_HOLD.
  - Function is_busy(state_t).
- No sub-module needed. The rising-edge detect is a single flop kept inline; run_ctrl is one FSM plus two counters.

Test Plan (START_HOLD=2, MAX_CYCLES=20, CNT_W=16):
- Reset, then req high for 2 cycles; core_halt pulsed on the 7th RUN cycle → INIT exactly 2 cycles with core_rst=1; done=1, timeout=0, cycle_count=7 after the halt edge; core_en=0 thereafter.
- core_halt never asserted → done=1, timeout=1, cycle_count=20 after the 20th RUN cycle. Repeat with core_halt=1 on exactly the 20th cycle → timeout=0, cycle_count=20.
- Second req pulse while RUN (cycle 3) → ignored: cycle_count keeps counting, only one done. Then req pulse in FIN → done drops next edge, new run gives cycle_count=new halt count.
- req held high through reset release → launch on the first edge; req kept high afterwards does not relaunch after done.
- reset=0 asserted mid-RUN at cycle 5 → core_rst=1, core_en=0, done=0, cycle_count=0 immediately, without waiting for a clock edge.
- MAX_CYCLES=0 build, halt withheld for 70000 cycles → no timeout, cycle_count saturates at 16'hFFFF.
